// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: mode codes from the control FSM,
// BCD digit limits and the default count resolution.
package stopwatch_pkg;

    typedef logic [1:0] en_t;

    localparam en_t EN_CLEAR = 2'b00;
    localparam en_t EN_RUN   = 2'b01;
    localparam en_t EN_HOLD  = 2'b10;

    localparam int CSEC_MAX        = 9;
    localparam int SEC_TENS_MAX    = 5;
    localparam int MIN_TENS_MAX    = 5;
    localparam int TICK_HZ_DEFAULT = 100;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the elapsed-time chain: counts 0..MAX on inc, clears on clr.
module bcd_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       at_max
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            // >= keeps the digit inside 0..MAX even from an unexpected value
            q_d = (q_q >= MAX_V) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == MAX_V);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch datapath: divides clk down to TICK_HZ and accumulates MM:SS.cc
// in six BCD digits under control of the 2-bit mode code.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = TICK_HZ_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  en_t        en,
    output logic [3:0] csec_ones,
    output logic [3:0] csec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       ovf
);

    localparam int DIV   = (TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 0;
    localparam int REM   = (TICK_HZ > 0) ? CLK_HZ % TICK_HZ : 1;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((DIV > 0) ? DIV - 1 : 0);

    generate
        if (DIV < 1 || REM != 0) begin : g_bad_div
            $error("stopwatch_counter: CLK_HZ/TICK_HZ must be an integer >= 1");
        end
    endgenerate

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             ovf_q, ovf_d;
    logic             clr;
    logic [5:0]       inc;
    logic [5:0]       at_max;
    logic [5:0][3:0]  dig;

    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        clr    = 1'b0;
        case (en)
            EN_RUN: begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            EN_HOLD: ;
            default: begin
                pre_d = '0;
                clr   = 1'b1;
            end
        endcase
    end

    assign ovf_d = tick_d & (&at_max);

    // Digit order: 0 csec_ones .. 5 min_tens; each carries only on a tick
    // with every lower digit at its limit.
    generate
        for (genvar i = 0; i < 6; i++) begin : g_dig
            localparam int MAX = (i == 3) ? SEC_TENS_MAX :
                                 (i == 5) ? MIN_TENS_MAX : CSEC_MAX;
            if (i == 0) begin : g_c0
                assign inc[i] = tick_d;
            end else begin : g_cn
                assign inc[i] = tick_d & (&at_max[i-1:0]);
            end
            bcd_digit #(.MAX(MAX)) u_dig (
                .clk    (clk),
                .reset  (reset),
                .clr    (clr),
                .inc    (inc[i]),
                .q      (dig[i]),
                .at_max (at_max[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            ovf_q  <= ovf_d;
        end
    end

    assign csec_ones = dig[0];
    assign csec_tens = dig[1];
    assign sec_ones  = dig[2];
    assign sec_tens  = dig[3];
    assign min_ones  = dig[4];
    assign min_tens  = dig[5];
    assign tick      = tick_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench: two counters (DIV=10 and DIV=1) share stimulus; a
// centisecond-count model predicts every cycle, a monitor compares at negedge.
module tb_stopwatch_counter;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] en;

    logic [3:0] co10, ct10, so10, st10, mo10, mt10, co1, ct1, so1, st1, mo1, mt1;
    logic       tick10, ovf10, tick1, ovf1;

    always #5 clk = ~clk;

    stopwatch_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut10 (
        .clk(clk), .reset(reset), .en(en),
        .csec_ones(co10), .csec_tens(ct10), .sec_ones(so10), .sec_tens(st10),
        .min_ones(mo10), .min_tens(mt10), .tick(tick10), .ovf(ovf10)
    );

    stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(100)) dut1 (
        .clk(clk), .reset(reset), .en(en),
        .csec_ones(co1), .csec_tens(ct1), .sec_ones(so1), .sec_tens(st1),
        .min_ones(mo1), .min_tens(mt1), .tick(tick1), .ovf(ovf1)
    );

    typedef struct {
        logic [25:0] v10;
        logic [25:0] v1;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    // Reference model: elapsed time as a plain count of hundredths.
    int divs[2]  = '{10, 1};
    int pre_m[2] = '{0, 0};
    int tot_m[2] = '{0, 0};

    function automatic logic [25:0] pack(int total, bit t, bit o);
        int mm, ss, cc;
        mm = total / 6000;
        ss = (total / 100) % 60;
        cc = total % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                4'(cc / 10), 4'(cc % 10), t, o};
    endfunction

    task automatic cyc(input bit r, input logic [1:0] e);
        logic [25:0] v[2];
        bit tk, ov;
        reset = r;
        en    = e;
        for (int k = 0; k < 2; k++) begin
            tk = 1'b0;
            ov = 1'b0;
            if (r) begin
                pre_m[k] = 0;
                tot_m[k] = 0;
            end else if (e == EN_RUN) begin
                if (pre_m[k] == divs[k] - 1) begin
                    pre_m[k] = 0;
                    tk = 1'b1;
                    ov = (tot_m[k] == 359999);
                    tot_m[k] = (tot_m[k] + 1) % 360000;
                end else begin
                    pre_m[k]++;
                end
            end else if (e != EN_HOLD) begin
                pre_m[k] = 0;
                tot_m[k] = 0;
            end
            v[k] = pack(tot_m[k], tk, ov);
        end
        sb.push_back('{v10: v[0], v1: v[1], cyc: ncyc});
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n, input logic [1:0] e);
        for (int i = 0; i < n; i++) cyc(1'b0, e);
    endtask

    // Jump dut1 to 59:59.98 by depositing digit state, avoiding 360k cycles.
    task automatic near_wrap();
        #5;
        force dut1.g_dig[0].u_dig.q_q = 4'd8;
        force dut1.g_dig[1].u_dig.q_q = 4'd9;
        force dut1.g_dig[2].u_dig.q_q = 4'd9;
        force dut1.g_dig[3].u_dig.q_q = 4'd5;
        force dut1.g_dig[4].u_dig.q_q = 4'd9;
        force dut1.g_dig[5].u_dig.q_q = 4'd5;
        tot_m[1] = 359998;
        cyc(1'b0, EN_HOLD);
        release dut1.g_dig[0].u_dig.q_q;
        release dut1.g_dig[1].u_dig.q_q;
        release dut1.g_dig[2].u_dig.q_q;
        release dut1.g_dig[3].u_dig.q_q;
        release dut1.g_dig[4].u_dig.q_q;
        release dut1.g_dig[5].u_dig.q_q;
        cyc(1'b0, EN_HOLD);
        run_n(4, EN_RUN);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [25:0] g10, g1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            g10 = {mt10, mo10, st10, so10, ct10, co10, tick10, ovf10};
            g1  = {mt1, mo1, st1, so1, ct1, co1, tick1, ovf1};
            checks++;
            if (g10 !== e.v10) begin
                errors++;
                $display("FAIL div10 cyc %0d got %h exp %h", e.cyc, g10, e.v10);
            end
            checks++;
            if (g1 !== e.v1) begin
                errors++;
                $display("FAIL div1 cyc %0d got %h exp %h", e.cyc, g1, e.v1);
            end
        end
    end

    initial begin
        int r;
        logic [1:0] e;
        // reset overrides run
        for (int i = 0; i < 3; i++) cyc(1'b1, EN_RUN);
        run_n(20, EN_RUN);
        // hold mid-interval then resume
        cyc(1'b0, EN_CLEAR);
        run_n(5, EN_RUN);
        run_n(30, EN_HOLD);
        run_n(12, EN_RUN);
        // dut1 carries through 01:00.00
        cyc(1'b0, 2'b11);
        run_n(6005, EN_RUN);
        // dut10 to 00:03.47, clear with 11, then clear with 00 at pre = DIV-1
        cyc(1'b0, EN_CLEAR);
        run_n(3470, EN_RUN);
        cyc(1'b0, 2'b11);
        run_n(3479, EN_RUN);
        cyc(1'b0, EN_CLEAR);
        run_n(25, EN_RUN);
        near_wrap();
        // random mode mix with occasional reset
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       e = EN_CLEAR;
            else if (r < 7)  e = 2'b11;
            else if (r < 25) e = EN_HOLD;
            else             e = EN_RUN;
            cyc($urandom_range(0, 99) == 0, e);
        end
        cyc(1'b0, EN_HOLD);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping datapath for the stopwatch, driven by the 2-bit `en` mode code from the stopwatch control FSM. It divides the system clock down to a 100 Hz tick and accumulates elapsed time as six BCD digits (MM:SS.cc) for the display path. It clears, runs or holds according to `en`. A pause keeps any partially counted tick, so pause/resume cycles lose no time.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TICK_HZ`, 100: count resolution. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 1; elaboration fails otherwise.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  2  mode: 00 clear, 01 run, 10 hold, 11 clear.
- `csec_ones`, `csec_tens`  out  4 each  hundredths digits, 0–9.
- `sec_ones`  out  4  seconds ones digit, 0–9.
- `sec_tens`  out  4  seconds tens digit, 0–5.
- `min_ones`  out  4  minutes ones digit, 0–9.
- `min_tens`  out  4  minutes tens digit, 0–5.
- `tick`  out  1  one-cycle pulse on each counted 1/TICK_HZ interval.
- `ovf`  out  1  one-cycle pulse when 59:59.99 wraps to 00:00.00.

## Operation
- Prescaler `pre`, width `$clog2(DIV)` (minimum 1 bit), counts 0..DIV-1.
- Reset: `pre`, all digits, `tick` and `ovf` go to 0. Reset overrides `en`.
- en = 00 or 11 (clear): on the next edge, `pre` and all digits go to 0. `tick` and `ovf` are 0.
- en = 01 (run):
  - If `pre` < DIV-1, `pre` increments.
  - If `pre` = DIV-1, `pre` goes to 0, `tick` = 1 for that cycle, and the digit chain advances by one count on the same edge.
- en = 10 (hold): `pre` and digits keep their values. `tick` and `ovf` are 0.
- Digit chain rollover, least significant first: csec_ones 9→0 carries; csec_tens 9→0 carries; sec_ones 9→0 carries; sec_tens 5→0 carries; min_ones 9→0 carries; min_tens 5→0.
- A digit advances only when the tick is present and every lower digit is at its maximum.
- Wrap: a tick at 59:59.99 sets every digit to 0 and pulses `ovf` together with `tick`.
- Mode changes take effect on the edge at which the new `en` is sampled. There are no priorities other than reset > `en`.
- The block never produces digit values outside their stated ranges.

## Timing
- All outputs are registered; no combinational path from `en` to any output.
- Starting from clear, with en = 01 held from edge 1, the first increment (and `tick`) is visible after edge DIV. Each further increment follows every DIV edges.
- Hold in mid-interval: if run resumes after hold, the next increment arrives after exactly (DIV − `pre` at hold) run cycles.
- Clear during the cycle where `pre` = DIV-1: clear wins, no tick, digits become 0.
- Reset mid-run: outputs are 0 the cycle after the reset edge. Counting restarts from 0 once reset deasserts and en = 01.
- DIV = 1: a tick on every run cycle.

## Structure
- Shared package `stopwatch_pkg`: `EN_CLEAR` = 2'b00, `EN_RUN` = 2'b01, `EN_HOLD` = 2'b10, and the `en_t` 2-bit type. The control FSM uses the same constants.
- The package also holds digit limits `CSEC_MAX` = 9, `SEC_TENS_MAX` = 5 and `MIN_TENS_MAX` = 5, and the default `TICK_HZ`.
- Sub-module `bcd_digit`:
  - Parameter: `MAX`.
  - Inputs: `clk`, `reset`, `clr`, `inc`.
  - Outputs: `q[3:0]`, `at_max`.
  - On `inc`, `q` advances and wraps from `MAX` to 0. `clr` forces `q` to 0.
  - Instantiated six times. The carry into each digit is `tick` AND all lower `at_max`.

## Test plan
- Reset with en = 01 asserted, using CLK_HZ = 10, TICK_HZ = 1 (DIV = 10): all digits, `tick` and `ovf` are 0 during reset and on the first cycle after it.
- DIV = 10, en = 01 for 10 edges: `csec_ones` = 1 after edge 10, `tick` high for exactly one cycle. After 20 edges `csec_ones` = 2.
- DIV = 10: run 5 edges, en = 10 for 30 edges, then run 5 edges. `csec_ones` 0→1 exactly on the 5th resumed edge; no change during hold.
- DIV = 1, run 100 edges: reads 00:01.00. After 6000 edges: 01:00.00. Check every `at_max` cascade boundary.
- DIV = 1, run 359,999 edges: reads 59:59.99. The next edge gives 00:00.00 with `ovf` = 1 and `tick` = 1 for one cycle.
- Running at 00:03.47:
  - en = 11 for one edge: all digits 0 and `pre` = 0.
  - Repeat with en = 00, landing on the cycle where `pre` = DIV-1: no `tick` pulse, digits 0.
